// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate instruction sequencer: ALU opcodes,
// instruction field layout, FSM state codes and the instruction packer.
package rotate_pkg;

    localparam logic [3:0] ALU_OP_WRITE = 4'h2;
    localparam logic [3:0] ALU_OP_ROTL1 = 4'h3;
    localparam logic [3:0] ALU_OP_NOP   = 4'hC;

    // Fixed-width fields below the address, LSB first
    localparam int GLOBAL_CMD_W = 3;
    localparam int ALU_OP_W     = 4;
    localparam int OUT_EN_W     = 1;
    localparam int OUT_SEL_W    = 1;
    localparam int IN_SEL_W     = 2;

    localparam int ALU_OP_OFS  = GLOBAL_CMD_W;
    localparam int OUT_EN_OFS  = ALU_OP_OFS + ALU_OP_W;
    localparam int OUT_SEL_OFS = OUT_EN_OFS + OUT_EN_W;
    localparam int IN_SEL_OFS  = OUT_SEL_OFS + OUT_SEL_W;
    localparam int ADDR_OFS    = IN_SEL_OFS + IN_SEL_W;

    // ram_write and save_core_selection sit above the address
    localparam int FIXED_W = ADDR_OFS + 2;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ROTATE = 2'd1;
    localparam logic [1:0] STATE_WRITE  = 2'd2;

    // Caller truncates the result to its own instruction width
    function automatic logic [63:0] pack_instr(input logic        ram_write,
                                               input logic [31:0] address,
                                               input int          addr_w,
                                               input logic [3:0]  opcode);
        logic [63:0] word;
        word = '0;
        word |= 64'(opcode) << ALU_OP_OFS;
        word |= 64'(address) << ADDR_OFS;
        word |= 64'(ram_write) << (ADDR_OFS + addr_w);
        return word;
    endfunction

endpackage

// File: rtl/rotate_state_machine.sv
// Emits the ROTL1/WRITE instruction stream that rotates one multi-limb RAM
// word left or right by an arbitrary bit count.
module rotate_state_machine
    import rotate_pkg::*;
#(
    parameter int  LIMB_WIDTH      = 16,
    parameter int  LIMB_COUNT      = 4,
    parameter int  WORD_ADDR_WIDTH = 6,
    localparam int TOTAL           = LIMB_WIDTH * LIMB_COUNT,
    localparam int BITS_W          = $clog2(TOTAL),
    localparam int LIMB_SEL_W      = $clog2(LIMB_COUNT),
    localparam int ROT_W           = $clog2(LIMB_WIDTH),
    localparam int ADDR_W          = WORD_ADDR_WIDTH + LIMB_SEL_W,
    localparam int INSTR_W         = FIXED_W + ADDR_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       dir_i,
    input  logic [BITS_W-1:0]          bits_i,
    input  logic [WORD_ADDR_WIDTH-1:0] address_i,
    output logic [INSTR_W-1:0]         instruction_o,
    output logic                       done_o,
    output logic                       busy_o
);

    logic [1:0]                 state;
    logic [ROT_W-1:0]           rot_cnt;
    logic [LIMB_SEL_W-1:0]      limb_cnt;
    logic                       dir_q;
    logic [BITS_W-1:0]          bits_q;
    logic [WORD_ADDR_WIDTH-1:0] addr_q;

    logic                       idle;
    logic                       cur_dir;
    logic [BITS_W-1:0]          cur_bits;
    logic [WORD_ADDR_WIDTH-1:0] cur_addr;
    logic [BITS_W-1:0]          left_amt;
    logic [ROT_W-1:0]           fine;
    logic [LIMB_SEL_W-1:0]      coarse;
    logic [LIMB_SEL_W-1:0]      k_cur;
    logic [LIMB_SEL_W-1:0]      limb_sel;
    logic                       is_write;
    logic                       drive;
    logic [INSTR_W-1:0]         instr;

    // The start cycle works from the live inputs; every later cycle from the latched copy
    always_comb begin
        idle     = (state == STATE_IDLE);
        cur_dir  = idle ? dir_i     : dir_q;
        cur_bits = idle ? bits_i    : bits_q;
        cur_addr = idle ? address_i : addr_q;
        left_amt = cur_dir ? (BITS_W'(0) - cur_bits) : cur_bits;
        fine     = left_amt[ROT_W-1:0];
        coarse   = left_amt[BITS_W-1:ROT_W];
        k_cur    = idle ? '0 : limb_cnt;
        limb_sel = coarse - k_cur;
        is_write = (state == STATE_WRITE) || (idle && (fine == '0));
        drive    = !idle || start_i;
        if (!drive) begin
            instr = INSTR_W'(pack_instr(1'b0, 32'd0, ADDR_W, ALU_OP_NOP));
        end else if (is_write) begin
            instr = INSTR_W'(pack_instr(1'b1, 32'({cur_addr, limb_sel}), ADDR_W, ALU_OP_WRITE));
        end else begin
            instr = INSTR_W'(pack_instr(1'b0, 32'd0, ADDR_W, ALU_OP_ROTL1));
        end
    end

    assign instruction_o = drive ? instr : 'z;
    assign busy_o        = !idle;
    assign done_o        = (state == STATE_WRITE) && (limb_cnt == LIMB_SEL_W'(LIMB_COUNT - 1));

    // rot_cnt holds the ROTL1s still owed after the current one; when the
    // start cycle already issued WRITE 0, the limb counter resumes at 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= STATE_IDLE;
            rot_cnt  <= '0;
            limb_cnt <= '0;
            dir_q    <= 1'b0;
            bits_q   <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (start_i) begin
                        dir_q  <= dir_i;
                        bits_q <= bits_i;
                        addr_q <= address_i;
                        if (fine > ROT_W'(1)) begin
                            state    <= STATE_ROTATE;
                            rot_cnt  <= fine - ROT_W'(2);
                            limb_cnt <= '0;
                        end else begin
                            state    <= STATE_WRITE;
                            limb_cnt <= (fine == '0) ? LIMB_SEL_W'(1) : '0;
                        end
                    end
                end
                STATE_ROTATE: begin
                    if (rot_cnt == '0) begin
                        state    <= STATE_WRITE;
                        limb_cnt <= '0;
                    end else begin
                        rot_cnt <= rot_cnt - ROT_W'(1);
                    end
                end
                STATE_WRITE: begin
                    limb_cnt <= limb_cnt + LIMB_SEL_W'(1);
                    if (limb_cnt == LIMB_SEL_W'(LIMB_COUNT - 1)) begin
                        state <= STATE_IDLE;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_state_machine.sv
// Directed bench for rotate_state_machine: a queue-based model of the expected
// instruction stream is checked every cycle, plus hand-computed literal values.
module tb_rotate_state_machine;

    localparam int TOTAL   = 64;
    localparam int LIMB_W  = 16;
    localparam int LIMBS   = 4;
    localparam int INSTR_W = 21;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic               busy;
        logic               done;
    } exp_t;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_i = 1'b0;
    logic               dir_i = 1'b0;
    logic [5:0]         bits_i = '0;
    logic [5:0]         address_i = '0;
    wire  [INSTR_W-1:0] instruction_o;
    logic               done_o;
    logic               busy_o;

    int vecCount  = 0;
    int failCount = 0;

    exp_t               expq[$];
    logic [INSTR_W-1:0] seen[$];
    logic               seenDone[$];

    // A released bus reads as all-zero; every real instruction is non-zero
    for (genvar g = 0; g < INSTR_W; g++) begin : g_pd
        pulldown (instruction_o[g]);
    end

    rotate_state_machine dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .dir_i        (dir_i),
        .bits_i       (bits_i),
        .address_i    (address_i),
        .instruction_o(instruction_o),
        .done_o       (done_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [INSTR_W-1:0] instrOf(input int ramWrite, input int addr, input int opcode);
        return INSTR_W'(ramWrite * (1 << 19) + addr * (1 << 11) + opcode * 8);
    endfunction

    // Expected stream: fine ROTL1s, then one WRITE per limb walking down from coarse
    task automatic buildSequence(input logic dir, input int bits, input int addr);
        int L, fine, coarse, len;
        L      = dir ? (TOTAL - bits) % TOTAL : bits;
        fine   = L % LIMB_W;
        coarse = L / LIMB_W;
        len    = fine + LIMBS;
        for (int i = 0; i < len; i++) begin
            exp_t e;
            if (i < fine) e.instr = instrOf(0, 0, 3);
            else          e.instr = instrOf(1, addr * LIMBS + (coarse - (i - fine) + LIMBS) % LIMBS, 2);
            e.busy = (i > 0);
            e.done = (i == len - 1);
            expq.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic dir, input int bits, input int addr);
        @(posedge clk_i);
        #1;
        dir_i     = dir;
        bits_i    = 6'(bits);
        address_i = 6'(addr);
        start_i   = 1'b1;
        if (expq.size() == 0) begin
            seen.delete();
            seenDone.delete();
            buildSequence(dir, bits, addr);
        end
        @(posedge clk_i);
        #1;
        start_i   = 1'b0;
        dir_i     = 1'($urandom);
        bits_i    = 6'($urandom);
        address_i = 6'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (expq.size() > 0 && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (expq.size() > 0) begin
            vecCount++;
            failCount++;
            $display("[TB] FAIL timeout: %0d instructions still pending, want 0", expq.size());
            expq.delete();
        end
    endtask

    function automatic logic [63:0] seenAt(input int idx);
        return (idx < seen.size()) ? 64'(seen[idx]) : '1;
    endfunction

    function automatic logic [63:0] doneAt(input int idx);
        return (idx < seenDone.size()) ? 64'(seenDone[idx]) : '1;
    endfunction

    // Every cycle out of reset the outputs must match the model's next entry (or idle)
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            if (expq.size() > 0) e = expq.pop_front();
            else                 e = '{instr: '0, busy: 1'b0, done: 1'b0};
            checkOutput("instr", 64'(instruction_o), 64'(e.instr));
            checkOutput("busy", 64'(busy_o), 64'(e.busy));
            checkOutput("done", 64'(done_o), 64'(e.done));
            seen.push_back(instruction_o);
            seenDone.push_back(done_o);
        end
    end

    initial begin
        #3;
        checkOutput("reset_instr", 64'(instruction_o), 64'h0);
        checkOutput("reset_busy", 64'(busy_o), 64'h0);
        checkOutput("reset_done", 64'(done_o), 64'h0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        applyStimulus(1'b0, 0, 5);
        waitIdle();
        checkOutput("left0_c0", seenAt(0), 64'h8A010);
        checkOutput("left0_c1", seenAt(1), 64'h8B810);
        checkOutput("left0_done3", doneAt(3), 64'h1);

        applyStimulus(1'b0, 1, 5);
        waitIdle();
        checkOutput("left1_c0", seenAt(0), 64'h00018);
        checkOutput("left1_c1", seenAt(1), 64'h8A010);
        checkOutput("left1_done4", doneAt(4), 64'h1);

        repeat (2) @(posedge clk_i);
        applyStimulus(1'b0, 37, 5);
        waitIdle();
        checkOutput("left37_c4", seenAt(4), 64'h00018);
        checkOutput("left37_c5", seenAt(5), 64'h8B010);
        checkOutput("left37_done7", doneAt(7), 64'h0);
        checkOutput("left37_done8", doneAt(8), 64'h1);

        applyStimulus(1'b1, 17, 5);
        waitIdle();
        checkOutput("right17_c14", seenAt(14), 64'h00018);
        checkOutput("right17_c15", seenAt(15), 64'h8B010);
        checkOutput("right17_done18", doneAt(18), 64'h1);

        applyStimulus(1'b1, 0, 5);
        waitIdle();
        checkOutput("right0_c0", seenAt(0), 64'h8A010);
        checkOutput("right0_c1", seenAt(1), 64'h8B810);

        // Re-start and new operands mid-sequence must be ignored
        repeat (3) @(posedge clk_i);
        applyStimulus(1'b0, 37, 5);
        applyStimulus(1'b0, 3, 9);
        waitIdle();
        checkOutput("ignored_c5", seenAt(5), 64'h8B010);
        checkOutput("ignored_done8", doneAt(8), 64'h1);
        applyStimulus(1'b0, 20, 3);
        waitIdle();
        checkOutput("b2b_c0", seenAt(0), 64'h00018);
        checkOutput("b2b_c4", seenAt(4), 64'h86810);

        applyStimulus(1'b0, 37, 5);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        expq.delete();
        #1;
        checkOutput("async_rst_instr", 64'(instruction_o), 64'h0);
        checkOutput("async_rst_busy", 64'(busy_o), 64'h0);
        checkOutput("async_rst_done", 64'(done_o), 64'h0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        applyStimulus(1'b0, 0, 5);
        waitIdle();
        checkOutput("post_rst_c0", seenAt(0), 64'h8A010);
        checkOutput("post_rst_done3", doneAt(3), 64'h1);

        repeat (3) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
